shared_dmem_arbiter: RTL and testbench
======================================

Name: shared_dmem_arbiter

Overview:
- Parametrised shared data memory with an N-port request/acknowledge front end, arbitrated round-robin or fixed-priority.
- Replaces the private per-PE Data_Memory instances in multi-PE tops, so N_PE processing elements share one word array.
- Provides a per-PE stall signal that freezes that PE's PC while its access is pending.
- Serves one access per cycle, with single-cycle acknowledge latency.

Parameters:
N_PE, 2, number of PE ports (2..8)
DEPTH, 1024, memory depth in 32-bit words (power of two)
AW, 10, log2(DEPTH), word-index width
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
req  in  N_PE  per-PE access request; held with we/addr/wdata stable until ack
we  in  N_PE  per-PE write enable (1 = store, 0 = load)
addr  in  N_PE*32  per-PE byte address; slice i = addr[32*i+31:32*i]
wdata  in  N_PE*32  per-PE store data
rdata  out  N_PE*32  per-PE load data, registered
ack  out  N_PE  per-PE completion pulse, one cycle per access
stall  out  N_PE  combinational: req[i] & ~ack[i]
conflict_cnt  out  32  count of cycles with more than one eligible requester

Behaviour:
- Reset (rst = 0, asynchronous):
  - ack = 0, rdata = 0, conflict_cnt = 0, rr_ptr = 0.
  - Memory contents are not reset.
- Eligibility:
  - eligible[i] = req[i] & ~ack[i].
  - A channel being acknowledged this cycle is masked, so a still-high req is never double-served.
- Arbitration, each cycle among eligible channels:
  - ARB_MODE 0: first eligible index searching upward from rr_ptr, wrapping modulo N_PE. On grant g, rr_ptr <= (g+1) mod N_PE. rr_ptr holds when nothing is granted.
  - ARB_MODE 1: lowest eligible index wins; rr_ptr unused.
- Access, granted in cycle t:
  - Word index = addr_g[AW+1:2]. addr bits [1:0] are ignored. Bits above AW+1 are ignored, so addresses wrap modulo DEPTH*4.
  - Write: mem[idx] <= wdata_g at the end of cycle t.
  - Read: rdata_g <= mem[idx] at the end of cycle t.
  - ack[g] = 1 during cycle t+1 only; all other ack bits are 0.
- rdata slice i:
  - Updates only on a read grant to channel i; otherwise holds its last value.
  - Write grants do not change rdata.
- Latency and throughput:
  - Uncontended access completes with ack one cycle after req rises.
  - One PE alone achieves at most one access per 2 cycles, because of masking.
  - With two or more contending, one grant per cycle.
- Fairness: in mode 0, any requester is granted within N_PE cycles of becoming eligible.
- Hazard: a write to X granted in cycle t, followed by a read of X granted in t+1, returns the new data (memory write at the end of t precedes the read).
- conflict_cnt:
  - Increments by 1 at the end of any cycle where popcount(eligible) >= 2.
  - Saturates at 32'hFFFFFFFF.
- Request withdrawal: dropping req before ack is a protocol violation; behaviour is undefined.
- Reset mid-operation:
  - An access granted in the cycle before reset asserts loses its ack.
  - A write completed at that edge stays in memory.
  - rr_ptr returns to 0.

Test Plan:
- Reset, then PE0 writes 32'hDEADBEEF to addr 0x10 -> ack[0] one cycle after req; stall[0] = 1 only in the req cycle. Then PE0 reads 0x10 -> rdata slice 0 = 32'hDEADBEEF with ack[0].
- ARB_MODE 0, N_PE = 4, all four req reads held continuously -> grant order 0,1,2,3,0,1,…; ack pattern rotates one-hot each cycle; conflict_cnt increments every contended cycle.
- ARB_MODE 1, PE0 and PE1 issue back-to-back requests, PE0 re-raising immediately after each ack -> PE1 granted only in PE0's masked cycles: alternating ack 01, 10.
- Address wrap, DEPTH = 1024: write 32'h12345678 to 0x0000_1004, read 0x0000_0004 -> 32'h12345678. Read 0x0000_0007 returns the same word.
- Write-then-read: PE0 writes 32'hA5A5A5A5 to 0x20 granted cycle t; PE1 read of 0x20 granted cycle t+1 -> rdata slice 1 = 32'hA5A5A5A5.
- rst pulled low while ack[2] is due -> ack = 0 and conflict_cnt = 0 immediately (asynchronous). After release, first grant starts from index 0.

Source files
------------

// File: rtl/shared_dmem_arbiter.sv
// Shared N-port word memory with round-robin or fixed-priority arbitration.
// One access per cycle; ack follows the grant by one cycle; per-PE stall.
module shared_dmem_arbiter #(
    parameter int N_PE     = 2,
    parameter int DEPTH    = 1024,
    parameter int AW       = 10,
    parameter int ARB_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PE-1:0]     req,
    input  logic [N_PE-1:0]     we,
    input  logic [N_PE*32-1:0]  addr,
    input  logic [N_PE*32-1:0]  wdata,
    output logic [N_PE*32-1:0]  rdata,
    output logic [N_PE-1:0]     ack,
    output logic [N_PE-1:0]     stall,
    output logic [31:0]         conflict_cnt
);
    localparam int PW = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam logic [PW-1:0] LAST = PW'(N_PE - 1);

    logic [31:0]     addr_w  [N_PE];
    logic [31:0]     wdata_w [N_PE];
    logic [31:0]     mem     [DEPTH];

    logic [N_PE-1:0] eligible;
    logic [N_PE-1:0] gnt_oh;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   hi_idx;
    logic [PW-1:0]   lo_idx;
    logic [PW-1:0]   gnt_idx;
    logic            hi_vld;
    logic            lo_vld;
    logic            gnt_vld;
    logic            multi;
    logic            sel_we;
    logic [AW-1:0]   sel_idx;
    logic [31:0]     sel_word;
    logic [31:0]     sel_wdata;
    logic            addr_unused;

    genvar g;
    for (g = 0; g < N_PE; g++) begin : g_slice
        logic [31:0] rd_q;

        assign addr_w[g]            = addr[32*g +: 32];
        assign wdata_w[g]           = wdata[32*g +: 32];
        assign rdata[32*g +: 32]    = rd_q;

        // Only a read grant to this channel refreshes its load data.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_q <= '0;
            end else if (gnt_oh[g] && !sel_we) begin
                rd_q <= mem[sel_idx];
            end
        end
    end

    // A channel whose ack is showing is masked so a held req is not re-served.
    assign eligible    = req & ~ack;
    assign stall       = req & ~ack;
    assign multi       = |(eligible & (eligible - N_PE'(1)));
    assign addr_unused = ^addr;

    always_comb begin : arb_scan
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = N_PE - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_vld = 1'b1;
                lo_idx = PW'(i);
                if (PW'(i) >= rr_ptr) begin
                    hi_vld = 1'b1;
                    hi_idx = PW'(i);
                end
            end
        end
    end

    always_comb begin : grant_sel
        gnt_vld = lo_vld;
        gnt_idx = lo_idx;
        if (ARB_MODE == 0 && hi_vld) begin
            gnt_idx = hi_idx;
        end
        for (int i = 0; i < N_PE; i++) begin
            gnt_oh[i] = gnt_vld && (gnt_idx == PW'(i));
        end
    end

    always_comb begin : access_mux
        sel_we    = gnt_vld & we[gnt_idx];
        sel_word  = addr_w[gnt_idx];
        sel_idx   = sel_word[AW+1:2];
        sel_wdata = wdata_w[gnt_idx];
    end

    always_ff @(posedge clk) begin
        if (gnt_vld && sel_we) begin
            mem[sel_idx] <= sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack          <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else begin
            ack <= gnt_oh;
            if (ARB_MODE == 0 && gnt_vld) begin
                rr_ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
            end
            if (multi && conflict_cnt != '1) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Bench for shared_dmem_arbiter: 4-port round-robin and 2-port
// fixed-priority instances driven from vector tables and short sequences.
module tb_shared_dmem_arbiter;
    localparam int NA = 4;

    typedef struct packed {
        logic [1:0]  pe;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } vec_t;

    typedef struct packed {
        logic [1:0]  pe;
        logic        rd;
        logic [31:0] data;
    } sb_t;

    logic clk;
    logic rst;

    logic [NA-1:0]    req_a;
    logic [NA-1:0]    we_a;
    logic [NA-1:0]    ack_a;
    logic [NA-1:0]    stall_a;
    logic [NA*32-1:0] addr_a;
    logic [NA*32-1:0] wdata_a;
    logic [NA*32-1:0] rdata_a;
    logic [31:0]      cnt_a;
    logic [31:0]      addr_u  [NA];
    logic [31:0]      wdata_u [NA];
    logic [31:0]      rdata_u [NA];

    logic [1:0]  req_b;
    logic [1:0]  we_b;
    logic [1:0]  ack_b;
    logic [1:0]  stall_b;
    logic [63:0] addr_b;
    logic [63:0] wdata_b;
    logic [63:0] rdata_b;
    logic [31:0] cnt_b;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt;
    logic [31:0] last_rd [NA];
    sb_t         sbq [$];
    vec_t        tbl [8];
    logic [31:0] rr_data [NA];
    logic [1:0]  exp_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NA; g++) begin : g_pack
        assign addr_a[32*g +: 32]  = addr_u[g];
        assign wdata_a[32*g +: 32] = wdata_u[g];
        assign rdata_u[g]          = rdata_a[32*g +: 32];
    end

    shared_dmem_arbiter #(
        .N_PE(4), .DEPTH(1024), .AW(10), .ARB_MODE(0)
    ) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a),
        .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a),
        .ack(ack_a), .stall(stall_a), .conflict_cnt(cnt_a)
    );

    shared_dmem_arbiter #(
        .N_PE(2), .DEPTH(1024), .AW(10), .ARB_MODE(1)
    ) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b),
        .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b),
        .ack(ack_b), .stall(stall_b), .conflict_cnt(cnt_b)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_access(input vec_t v);
        sb_t e;
        sb_t got;
        int  lat;
        @(negedge clk);
        req_a[v.pe]   = 1'b1;
        we_a[v.pe]    = v.w;
        addr_u[v.pe]  = v.a;
        wdata_u[v.pe] = v.w ? v.d : 32'h0;
        e.pe   = v.pe;
        e.rd   = !v.w;
        e.data = v.d;
        sbq.push_back(e);
        #1 check("stall_req_cycle", 32'(stall_a[v.pe]), 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack_a[v.pe] && lat < 8);
        check("ack_latency", lat, 32'd1);
        check("ack_onehot", 32'(ack_a), 32'(4'b0001 << v.pe));
        check("stall_ack_cycle", 32'(stall_a[v.pe]), 32'd0);
        got = sbq.pop_front();
        if (got.rd) begin
            check("rdata_read", rdata_u[got.pe], got.data);
            last_rd[got.pe] = got.data;
        end else begin
            check("rdata_hold_on_write", rdata_u[got.pe], last_rd[got.pe]);
        end
        req_a[v.pe] = 1'b0;
        we_a[v.pe]  = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        req_a   = '0;
        we_a    = '0;
        req_b   = '0;
        we_b    = '0;
        addr_b  = '0;
        wdata_b = '0;
        exp_cnt = '0;
        for (int i = 0; i < NA; i++) begin
            addr_u[i]  = '0;
            wdata_u[i] = '0;
            last_rd[i] = '0;
        end

        tbl[0] = '{pe: 2'd0, w: 1'b1, a: 32'h0000_0010, d: 32'hDEADBEEF};
        tbl[1] = '{pe: 2'd0, w: 1'b0, a: 32'h0000_0010, d: 32'hDEADBEEF};
        tbl[2] = '{pe: 2'd2, w: 1'b1, a: 32'h0000_1004, d: 32'h12345678};
        tbl[3] = '{pe: 2'd3, w: 1'b0, a: 32'h0000_0004, d: 32'h12345678};
        tbl[4] = '{pe: 2'd1, w: 1'b0, a: 32'h0000_0007, d: 32'h12345678};
        tbl[5] = '{pe: 2'd3, w: 1'b1, a: 32'h0000_3FFC, d: 32'h0000_0055};
        tbl[6] = '{pe: 2'd0, w: 1'b0, a: 32'h0000_0FFC, d: 32'h0000_0055};
        tbl[7] = '{pe: 2'd1, w: 1'b0, a: 32'h0000_0010, d: 32'hDEADBEEF};

        rr_data[0] = 32'hDEADBEEF;
        rr_data[1] = 32'hA5A5A5A5;
        rr_data[2] = 32'h12345678;
        rr_data[3] = 32'h0000_0055;

        repeat (2) @(negedge clk);
        check("reset_ack", 32'(ack_a), 32'd0);
        check("reset_cnt", cnt_a, 32'd0);
        check("reset_rdata0", rdata_u[0], 32'd0);
        check("reset_rdata3", rdata_u[3], 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_access(tbl[i]);
        end
        check("table_cnt", cnt_a, exp_cnt);

        // Write by PE0 then read of the same word by PE1 one cycle later.
        @(negedge clk);
        addr_u[0]  = 32'h20;
        wdata_u[0] = 32'hA5A5A5A5;
        addr_u[1]  = 32'h20;
        we_a       = 4'b0001;
        req_a      = 4'b0011;
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        check("haz_ack_w", 32'(ack_a), 32'h1);
        check("haz_stall1", 32'(stall_a[1]), 32'd1);
        check("haz_cnt", cnt_a, exp_cnt);
        req_a[0] = 1'b0;
        we_a     = '0;
        @(negedge clk);
        check("haz_ack_r", 32'(ack_a), 32'h2);
        check("haz_rdata", rdata_u[1], 32'hA5A5A5A5);
        check("haz_cnt_hold", cnt_a, exp_cnt);
        req_a[1] = 1'b0;
        last_rd[1] = 32'hA5A5A5A5;

        // All four read continuously; pointer sits at 2 after the last grant.
        @(negedge clk);
        for (int i = 0; i < NA; i++) begin
            addr_u[i] = (i == 0) ? 32'h10 : (i == 1) ? 32'h20 :
                        (i == 2) ? 32'h4 : 32'hFFC;
        end
        req_a   = 4'hF;
        exp_ptr = 2'd2;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_cnt = exp_cnt + 32'd1;
            check("rr_ack", 32'(ack_a), 32'(4'b0001 << exp_ptr));
            check("rr_rdata", rdata_u[exp_ptr], rr_data[exp_ptr]);
            check("rr_cnt", cnt_a, exp_cnt);
            if (k < 5) exp_ptr = exp_ptr + 2'd1;
        end

        // ack[2] is showing now; reset must clear it at once.
        rst = 1'b0;
        #1;
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_cnt", cnt_a, 32'd0);
        check("rst_rdata2", rdata_u[2], 32'd0);
        exp_cnt = '0;
        @(negedge clk);
        rst     = 1'b1;
        exp_ptr = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_cnt = exp_cnt + 32'd1;
            check("post_rst_ack", 32'(ack_a), 32'(4'b0001 << exp_ptr));
            check("post_rst_rdata", rdata_u[exp_ptr], rr_data[exp_ptr]);
            check("post_rst_cnt", cnt_a, exp_cnt);
            exp_ptr = exp_ptr + 2'd1;
        end
        req_a = '0;
        @(negedge clk);
        @(negedge clk);
        check("idle_ack", 32'(ack_a), 32'd0);

        // Fixed priority: PE1 only wins in PE0's masked cycles.
        req_b = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("prio_ack", 32'(ack_b), (k % 2 == 1) ? 32'h1 : 32'h2);
        end
        req_b = '0;
        @(negedge clk);
        check("prio_cnt", cnt_b, 32'd1);
        check("prio_idle_ack", 32'(ack_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
